control_acceso: RTL

CONTROL_ACCESO -- requirements
Module: control_acceso

---
 rtl/control_acceso.sv | 130 +++++++++++++
 1 files changed

// File: rtl/control_acceso.sv
`timescale 1ns/1ps
// control_acceso
// Keypad access controller. Each rising edge of the enter key is one attempt.
// A correct code opens the door for T_PUERTA cycles. After MAX_INTENTOS
// consecutive wrong codes, the controller raises the alarm and locks out
// the keypad for T_BLOQUEO cycles. All outputs are registered (Moore).
//
// Ports
//   clk            : single clock, rising edge
//   rst            : asynchronous reset, active low
//   enter          : keypad enter key (level)
//   verificacion   : 1 when the entered code matches, sampled on the attempt
//   puerta_abierta : door release
//   alarma         : alarm, high while locked out
//   bloqueo        : lockout indicator, always equal to alarma
//   intentos       : consecutive failed attempts so far
module control_acceso #(
  parameter int T_PUERTA     = 8,
  parameter int MAX_INTENTOS = 3,
  parameter int T_BLOQUEO    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       verificacion,
  output logic       puerta_abierta,
  output logic       alarma,
  output logic       bloqueo,
  output logic [1:0] intentos
);

  typedef enum logic [1:0] {
    ESPERA,
    ABIERTO,
    BLOQUEADO
  } state_t;

  // Timers are loaded with duration-1 because the load cycle itself counts
  // as the first active cycle of the output.
  localparam logic [7:0] PUERTA_LOAD  = 8'(T_PUERTA - 1);
  localparam logic [7:0] BLOQUEO_LOAD = 8'(T_BLOQUEO - 1);
  localparam logic [2:0] MAX_WIDE     = 3'(MAX_INTENTOS);
  localparam logic [1:0] MAX_COUNT    = 2'(MAX_INTENTOS);

  state_t     state;
  state_t     state_next;
  logic [7:0] timer;
  logic [7:0] timer_next;
  logic [1:0] intentos_next;
  logic       enter_q;
  logic       attempt;
  logic [2:0] fallos_next;

  // An attempt is a 0->1 transition of enter. enter_q keeps tracking enter in
  // every state, so a key that is still held when the controller returns to
  // ESPERA does not produce a new attempt.
  assign attempt     = enter & ~enter_q;
  // Widened by one bit so the comparison against MAX_INTENTOS cannot overflow.
  assign fallos_next = {1'b0, intentos} + 3'd1;

  // Next-state logic. Attempts are acted on only in ESPERA. In the timed
  // states, expiry is checked first, so an attempt that coincides with it is
  // discarded.
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    intentos_next = intentos;
    case (state)
      ESPERA: begin
        if (attempt) begin
          if (verificacion) begin
            state_next    = ABIERTO;
            intentos_next = 2'd0;
            timer_next    = PUERTA_LOAD;
          end else if (fallos_next < MAX_WIDE) begin
            intentos_next = fallos_next[1:0];
          end else begin
            state_next    = BLOQUEADO;
            intentos_next = MAX_COUNT;
            timer_next    = BLOQUEO_LOAD;
          end
        end
      end
      ABIERTO: begin
        if (timer == 8'd0) begin
          state_next = ESPERA;
        end else begin
          timer_next = timer - 8'd1;
        end
      end
      BLOQUEADO: begin
        if (timer == 8'd0) begin
          state_next    = ESPERA;
          intentos_next = 2'd0;
        end else begin
          timer_next = timer - 8'd1;
        end
      end
      default: begin
        state_next    = ESPERA;
        timer_next    = 8'd0;
        intentos_next = 2'd0;
      end
    endcase
  end

  // State and output registers. The outputs are decoded from the next state
  // and then registered. They therefore change on the same edge as the
  // state, and there is no combinational path from the inputs to the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ESPERA;
      timer          <= 8'd0;
      intentos       <= 2'd0;
      enter_q        <= 1'b0;
      puerta_abierta <= 1'b0;
      alarma         <= 1'b0;
      bloqueo        <= 1'b0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      intentos       <= intentos_next;
      enter_q        <= enter;
      puerta_abierta <= (state_next == ABIERTO);
      alarma         <= (state_next == BLOQUEADO);
      bloqueo        <= (state_next == BLOQUEADO);
    end
  end

endmodule
